// File: rtl/vec_lane_sequencer.sv
// Vector lane sequencer: steps one vector instruction through the execute lanes
// LANES elements per cycle, stalling the front end until the op writes back.
module vec_lane_sequencer #(
  parameter int VLEN  = 8,
  parameter int LANES = 2,
  parameter int RA_W  = 4,
  parameter int IDX_W = $clog2(VLEN),
  parameter int CNT_W = $clog2(VLEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [CNT_W-1:0] vlen_i,
  input  logic             mem_op_i,
  input  logic [RA_W-1:0]  wa_i,
  input  logic             reg_write_i,
  input  logic             flush_i,
  input  logic             mem_ack_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             lane_valid_o,
  output logic [IDX_W-1:0] elem_idx_o,
  output logic [LANES-1:0] lane_en_o,
  output logic             mem_req_o,
  output logic             wb_en_o,
  output logic [RA_W-1:0]  wb_addr_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] VLEN_C  = CNT_W'(VLEN);
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
  // When LANES == VLEN the step truncates to zero, which is the correct mod-VLEN index.
  localparam logic [IDX_W-1:0] STEP_C  = IDX_W'(LANES);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             mem_q, mem_d;
  logic             wen_q, wen_d;
  logic [RA_W-1:0]  wa_q, wa_d;

  logic [CNT_W-1:0] vlen_clamped;
  logic             retire;
  logic [LANES-1:0] lane_mask;

  always_comb begin
    vlen_clamped = (vlen_i > VLEN_C) ? VLEN_C : vlen_i;
    retire       = (state_q == EXEC) && (!mem_q || mem_ack_i);
  end

  // Lane k is live while at least k+1 elements remain.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_mask[k] = (rem_q > CNT_W'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    mem_d   = mem_q;
    wen_d   = wen_q;
    wa_d    = wa_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          idx_d   = '0;
          rem_d   = vlen_clamped;
          mem_d   = mem_op_i;
          wa_d    = wa_i;
          // A zero-length op still reports done but must not write the register file.
          wen_d   = reg_write_i && (vlen_clamped != '0);
          state_d = (vlen_clamped == '0) ? WB : EXEC;
        end
      end
      EXEC: begin
        if (retire) begin
          idx_d = idx_q + STEP_C;
          if (rem_q <= LANES_C) begin
            rem_d   = '0;
            state_d = WB;
          end else begin
            rem_d = rem_q - LANES_C;
          end
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      mem_q   <= 1'b0;
      wen_q   <= 1'b0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      mem_q   <= mem_d;
      wen_q   <= wen_d;
      wa_q    <= wa_d;
    end
  end

  // Outputs decode registered state only, so they stay stable across a memory wait.
  always_comb begin
    busy_o       = (state_q != IDLE);
    stall_o      = busy_o;
    lane_valid_o = (state_q == EXEC);
    elem_idx_o   = lane_valid_o ? idx_q : '0;
    lane_en_o    = lane_valid_o ? lane_mask : '0;
    mem_req_o    = lane_valid_o && mem_q;
    done_o       = (state_q == WB);
    wb_en_o      = done_o && wen_q;
    wb_addr_o    = wa_q;
  end

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Self-checking bench for vec_lane_sequencer: directed scenarios plus randomized
// ops compared against a cycle-trace model built from element counts and lane width.
module tb_vec_lane_sequencer;

  localparam int VLEN  = 8;
  localparam int LANES = 2;
  localparam int RA_W  = 4;
  localparam int IDX_W = $clog2(VLEN);
  localparam int CNT_W = $clog2(VLEN + 1);
  localparam int OW    = 3 + IDX_W + LANES + 2 + RA_W + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_i;
  logic [CNT_W-1:0] vlen_i;
  logic             mem_op_i;
  logic [RA_W-1:0]  wa_i;
  logic             reg_write_i;
  logic             flush_i;
  logic             mem_ack_i;
  logic             busy_o;
  logic             stall_o;
  logic             lane_valid_o;
  logic [IDX_W-1:0] elem_idx_o;
  logic [LANES-1:0] lane_en_o;
  logic             mem_req_o;
  logic             wb_en_o;
  logic [RA_W-1:0]  wb_addr_o;
  logic             done_o;

  int checks = 0;
  int errors = 0;
  logic [RA_W-1:0] last_wa = '0;

  logic [OW-1:0] out_vec;
  assign out_vec = {busy_o, stall_o, lane_valid_o, elem_idx_o, lane_en_o,
                    mem_req_o, wb_en_o, wb_addr_o, done_o};

  always #5 clk = ~clk;

  vec_lane_sequencer #(
    .VLEN (VLEN),
    .LANES(LANES),
    .RA_W (RA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .vlen_i      (vlen_i),
    .mem_op_i    (mem_op_i),
    .wa_i        (wa_i),
    .reg_write_i (reg_write_i),
    .flush_i     (flush_i),
    .mem_ack_i   (mem_ack_i),
    .busy_o      (busy_o),
    .stall_o     (stall_o),
    .lane_valid_o(lane_valid_o),
    .elem_idx_o  (elem_idx_o),
    .lane_en_o   (lane_en_o),
    .mem_req_o   (mem_req_o),
    .wb_en_o     (wb_en_o),
    .wb_addr_o   (wb_addr_o),
    .done_o      (done_o)
  );

  // The pipeline is stalled while busy, so a start then is a bench protocol error.
  always @(posedge clk) begin
    if (!reset && start_i && busy_o) begin
      errors++;
      $display("[TB] FAIL protocol: start_i=1 while busy_o=1 at %0t, required no start", $time);
    end
  end

  function automatic logic [OW-1:0] pack(input logic busy, input logic lv,
                                          input logic [IDX_W-1:0] idx,
                                          input logic [LANES-1:0] en,
                                          input logic mr, input logic wb,
                                          input logic [RA_W-1:0] addr,
                                          input logic done);
    return {busy, busy, lv, idx, en, mr, wb, addr, done};
  endfunction

  function automatic logic [LANES-1:0] mask_of(input int active);
    logic [LANES-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) if (k < active) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [OW-1:0] idle_vec(input logic [RA_W-1:0] addr);
    return pack(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, addr, 1'b0);
  endfunction

  function automatic logic [OW-1:0] exec_vec(input int idx, input int active,
                                              input logic mr, input logic [RA_W-1:0] addr);
    return pack(1'b1, 1'b1, IDX_W'(idx % VLEN), mask_of(active), mr, 1'b0, addr, 1'b0);
  endfunction

  function automatic logic [OW-1:0] wb_vec(input logic wb, input logic [RA_W-1:0] addr);
    return pack(1'b1, 1'b0, '0, '0, 1'b0, wb, addr, 1'b1);
  endfunction

  task automatic drive_idle();
    start_i     = 1'b0;
    vlen_i      = '0;
    mem_op_i    = 1'b0;
    wa_i        = '0;
    reg_write_i = 1'b0;
    flush_i     = 1'b0;
    mem_ack_i   = 1'b0;
  endtask

  task automatic start_op(input int n, input logic mem, input logic [RA_W-1:0] wa,
                          input logic rw);
    start_i     = 1'b1;
    vlen_i      = CNT_W'(n);
    mem_op_i    = mem;
    wa_i        = wa;
    reg_write_i = rw;
    last_wa     = wa;
  endtask

  task automatic test_reset();
    $display("[TB] running test_reset");
    reset = 1'b1;
    drive_idle();
    #1;
    checks++;
    if (out_vec !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: actual %h required %h", out_vec, {OW{1'b0}});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vec !== idle_vec('0)) begin
      errors++;
      $display("[TB] FAIL reset_idle: actual %h required %h", out_vec, idle_vec('0));
    end
  endtask

  task automatic test_full_vector();
    logic [OW-1:0] exp_v;
    $display("[TB] running test_full_vector");
    @(negedge clk);
    start_op(8, 1'b0, 4'd5, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      exp_v = exec_vec((c - 1) * LANES, LANES, 1'b0, 4'd5);
      checks++;
      if (out_vec !== exp_v) begin
        errors++;
        $display("[TB] FAIL pre_reset_c%0d: actual %h required %h", c, out_vec, exp_v);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_vec !== '0) begin
      errors++;
      $display("[TB] FAIL mid_exec_reset: actual %h required %h", out_vec, {OW{1'b0}});
    end
    last_wa = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vec !== idle_vec('0)) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: actual %h required %h", out_vec, idle_vec('0));
    end
    start_op(8, 1'b0, 4'd9, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c <= 4)      exp_v = exec_vec((c - 1) * LANES, LANES, 1'b0, 4'd9);
      else if (c == 5) exp_v = wb_vec(1'b1, 4'd9);
      else             exp_v = idle_vec(4'd9);
      checks++;
      if (out_vec !== exp_v) begin
        errors++;
        $display("[TB] FAIL full_c%0d: actual %h required %h", c, out_vec, exp_v);
      end
    end
  endtask

  task automatic test_partial();
    logic [OW-1:0] exp_t[5];
    $display("[TB] running test_partial");
    exp_t[0] = exec_vec(0, 2, 1'b0, 4'd3);
    exp_t[1] = exec_vec(2, 2, 1'b0, 4'd3);
    exp_t[2] = exec_vec(4, 1, 1'b0, 4'd3);
    exp_t[3] = wb_vec(1'b1, 4'd3);
    exp_t[4] = idle_vec(4'd3);
    start_op(5, 1'b0, 4'd3, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (out_vec !== exp_t[c-1]) begin
        errors++;
        $display("[TB] FAIL partial_c%0d: actual %h required %h", c, out_vec, exp_t[c-1]);
      end
    end
  endtask

  task automatic test_mem_op();
    logic [OW-1:0] exp_t[6];
    logic          ack_t[6];
    $display("[TB] running test_mem_op");
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    checks++;
    if (out_vec !== idle_vec(4'd3)) begin
      errors++;
      $display("[TB] FAIL idle_ack_ignored: actual %h required %h", out_vec, idle_vec(4'd3));
    end
    exp_t[0] = exec_vec(0, 2, 1'b1, 4'd7); ack_t[0] = 1'b0;
    exp_t[1] = exec_vec(0, 2, 1'b1, 4'd7); ack_t[1] = 1'b0;
    exp_t[2] = exec_vec(0, 2, 1'b1, 4'd7); ack_t[2] = 1'b1;
    exp_t[3] = exec_vec(2, 2, 1'b1, 4'd7); ack_t[3] = 1'b1;
    exp_t[4] = wb_vec(1'b1, 4'd7);         ack_t[4] = 1'b0;
    exp_t[5] = idle_vec(4'd7);             ack_t[5] = 1'b0;
    start_op(4, 1'b1, 4'd7, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (out_vec !== exp_t[c-1]) begin
        errors++;
        $display("[TB] FAIL mem_c%0d: actual %h required %h", c, out_vec, exp_t[c-1]);
      end
      mem_ack_i = ack_t[c-1];
    end
  endtask

  task automatic test_flush();
    logic [OW-1:0] exp_v;
    $display("[TB] running test_flush");
    start_op(8, 1'b0, 4'd3, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      flush_i = (c == 2);
      exp_v = (c <= 2) ? exec_vec((c - 1) * LANES, LANES, 1'b0, 4'd3) : idle_vec(4'd3);
      checks++;
      if (out_vec !== exp_v) begin
        errors++;
        $display("[TB] FAIL flush_c%0d: actual %h required %h", c, out_vec, exp_v);
      end
    end
    start_op(2, 1'b0, 4'd1, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == 1)      exp_v = exec_vec(0, 2, 1'b0, 4'd1);
      else if (c == 2) exp_v = wb_vec(1'b1, 4'd1);
      else             exp_v = idle_vec(4'd1);
      checks++;
      if (out_vec !== exp_v) begin
        errors++;
        $display("[TB] FAIL after_flush_c%0d: actual %h required %h", c, out_vec, exp_v);
      end
    end
  endtask

  task automatic test_zero_len_clamp();
    logic [OW-1:0] exp_v;
    $display("[TB] running test_zero_len_clamp");
    start_op(0, 1'b0, 4'd6, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      exp_v = (c == 1) ? wb_vec(1'b0, 4'd6) : idle_vec(4'd6);
      checks++;
      if (out_vec !== exp_v) begin
        errors++;
        $display("[TB] FAIL zero_len_c%0d: actual %h required %h", c, out_vec, exp_v);
      end
    end
    start_op(12, 1'b0, 4'd10, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c <= 4)      exp_v = exec_vec((c - 1) * LANES, LANES, 1'b0, 4'd10);
      else if (c == 5) exp_v = wb_vec(1'b0, 4'd10);
      else             exp_v = idle_vec(4'd10);
      checks++;
      if (out_vec !== exp_v) begin
        errors++;
        $display("[TB] FAIL clamp_c%0d: actual %h required %h", c, out_vec, exp_v);
      end
    end
  endtask

  task automatic test_start_flush();
    $display("[TB] running test_start_flush");
    start_i     = 1'b1;
    flush_i     = 1'b1;
    vlen_i      = CNT_W'(5);
    wa_i        = 4'd2;
    reg_write_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive_idle();
      checks++;
      if (out_vec !== idle_vec(last_wa)) begin
        errors++;
        $display("[TB] FAIL start_flush_c%0d: actual %h required %h", c, out_vec,
                 idle_vec(last_wa));
      end
    end
  endtask

  // Expected trace per op: each chunk lasts 1 + memory wait cycles, then one WB cycle.
  task automatic test_random();
    logic [OW-1:0] exp_q[$];
    logic          ack_q[$];
    $display("[TB] running test_random");
    for (int op = 0; op < 60; op++) begin
      int n, n_eff, gap, fl, exec_len;
      logic mem, rw;
      logic [RA_W-1:0] wa;
      n   = $urandom_range(0, 15);
      mem = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      wa  = RA_W'($urandom_range(0, (1 << RA_W) - 1));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        drive_idle();
        mem_ack_i = 1'($urandom_range(0, 1));
        checks++;
        if (out_vec !== idle_vec(last_wa)) begin
          errors++;
          $display("[TB] FAIL rand_gap op%0d: actual %h required %h", op, out_vec,
                   idle_vec(last_wa));
        end
      end
      @(negedge clk);
      drive_idle();
      n_eff = (n > VLEN) ? VLEN : n;
      exp_q.delete();
      ack_q.delete();
      for (int c = 0; c * LANES < n_eff; c++) begin
        int left, act, wt;
        left = n_eff - c * LANES;
        act  = (left < LANES) ? left : LANES;
        wt   = mem ? $urandom_range(0, 3) : 0;
        for (int w = 0; w <= wt; w++) begin
          exp_q.push_back(exec_vec(c * LANES, act, mem, wa));
          ack_q.push_back(mem && (w == wt));
        end
      end
      exec_len = exp_q.size();
      exp_q.push_back(wb_vec(rw && (n_eff > 0), wa));
      ack_q.push_back(1'b0);
      fl = -1;
      if (exec_len > 0 && $urandom_range(0, 3) == 0) begin
        fl = $urandom_range(0, exec_len - 1);
        while (exp_q.size() > fl + 1) void'(exp_q.pop_back());
      end
      start_op(n, mem, wa, rw);
      for (int j = 0; j < exp_q.size(); j++) begin
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (out_vec !== exp_q[j]) begin
          errors++;
          $display("[TB] FAIL rand op%0d cyc%0d n=%0d mem=%0b: actual %h required %h",
                   op, j, n, mem, out_vec, exp_q[j]);
        end
        mem_ack_i = mem ? ack_q[j] : 1'($urandom_range(0, 1));
        flush_i   = (j == fl);
      end
      @(negedge clk);
      drive_idle();
      checks++;
      if (out_vec !== idle_vec(last_wa)) begin
        errors++;
        $display("[TB] FAIL rand_end op%0d: actual %h required %h", op, out_vec,
                 idle_vec(last_wa));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_partial();
    test_mem_op();
    test_flush();
    test_zero_len_clamp();
    test_start_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_lane_sequencer.md
Name: vec_lane_sequencer

Overview:
Sequences one multi-element vector instruction through the execute datapath, LANES elements per cycle. It holds the pipeline front end stalled through the hazard unit until the last chunk retires. It drives element index, lane-enable mask and memory handshake for vector load/store, then issues a single register-file write strobe. It sits beside hazard_unit in the Execute stage; its stall_o is ORed into StallF/StallD.

Parameters:
VLEN, 8, maximum elements per vector register (power of 2, >= LANES)
LANES, 2, elements processed per cycle (power of 2, 1..VLEN)
RA_W, 4, register address width (matches RA1E/WA3E)
IDX_W, $clog2(VLEN), element index width (derived)
CNT_W, $clog2(VLEN+1), element count width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start_i  in  1  vector op valid in E this cycle (one-cycle pulse)
vlen_i  in  CNT_W  active element count for the op, 0..VLEN
mem_op_i  in  1  op is a vector load/store (per-chunk memory handshake)
wa_i  in  RA_W  destination vector register
reg_write_i  in  1  op writes the register file
flush_i  in  1  abort current op (branch flush / FlushE)
mem_ack_i  in  1  memory accepted/returned current chunk
busy_o  out  1  state != IDLE
stall_o  out  1  stall request to hazard unit, = busy_o
lane_valid_o  out  1  chunk active on datapath this cycle
elem_idx_o  out  IDX_W  first element index of current chunk
lane_en_o  out  LANES  per-lane enable for current chunk
mem_req_o  out  1  memory request for current chunk
wb_en_o  out  1  register-file write strobe (one cycle)
wb_addr_o  out  RA_W  latched destination register
done_o  out  1  op completed (one cycle)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset, async: state=IDLE; every output 0; internal idx, remaining, latched wa/mem/reg_write cleared.
- States: IDLE, EXEC, WB.
- IDLE: on start_i, latch vlen_i→remaining, mem_op_i, wa_i, reg_write_i; idx=0.
  - vlen_i>0 → EXEC.
  - vlen_i==0 → WB with wb_en suppressed (done only).
- EXEC: lane_valid_o=1, elem_idx_o=idx.
  - lane_en_o bit k = (k < remaining); remaining≥LANES gives all ones.
  - Non-mem op: chunk retires every cycle.
  - Mem op: mem_req_o=1 and outputs held stable until mem_ack_i; chunk retires in the ack cycle. Ack in the first EXEC cycle is legal (zero wait).
  - On retire: idx+=LANES, remaining-=min(LANES,remaining). Retire with remaining≤LANES → WB.
- WB: one cycle. wb_en_o=latched reg_write (0 if vlen was 0); done_o=1; wb_addr_o valid; → IDLE.
- Outputs: all registered from state/counters, combinational decode of state only. wb_addr_o holds its last value in IDLE.
- Latency, no mem waits: done_o is asserted ceil(n/LANES)+1 cycles after the start_i cycle. busy_o rises the cycle after start_i.
- flush_i: any state → IDLE next edge. No wb_en/done for the aborted op. flush_i with start_i in IDLE: flush wins, op not accepted.
- start_i while busy: ignored; the pipeline is stalled, so this is a protocol error and the bench asserts it never happens.
- vlen_i>VLEN: clamp to VLEN.
- idx arithmetic: mod VLEN. The last chunk never wraps because of the clamp.
- mem_ack_i outside an EXEC/mem_req cycle: ignored.

Test Plan:
- Reset mid-EXEC (VLEN=8, LANES=2, vlen=8, no mem) → all outputs 0 immediately; after reset release, IDLE with busy_o=0. Then start → EXEC idx 0,2,4,6 with lane_en=11 on cycles 1-4; WB cycle 5: wb_en=1, done=1, wb_addr=wa_i; busy_o=0 at cycle 6.
- Partial vector vlen=5 → chunks idx 0,2,4 with lane_en 11,11,01; done 4 cycles after start.
- Mem op vlen=4, mem_ack delayed 2 cycles on chunk 0 and immediate on chunk 1 → mem_req high 3 cycles at idx 0, then 1 cycle at idx 2; elem_idx/lane_en stable while waiting; done at cycle 5.
- flush_i asserted during second EXEC chunk → IDLE next cycle, wb_en and done never asserted. A following start runs normally.
- vlen_i=0 with reg_write_i=1 → WB next cycle: done=1, wb_en=0, lane_valid never asserted. vlen_i=12 → behaves as 8.
- start_i and flush_i in the same IDLE cycle → busy_o stays 0, no lane activity.
